axis_block_sig_gen: RTL
=======================

Name: axis_block_sig_gen

Overview:
- Upstream stage of the per-instance deadlock monitors in the cosim harness.
- Watches the AXIS/FIFO handshakes of the dataflow channels and produces the `axis_block_sigs` vector those monitors consume.
- A channel bit asserts only after a stall has lasted `STALL_THRESH` consecutive cycles. This filters out normal backpressure.
- Also latches the index of the first channel to block, for the deadlock report.

Parameters:
- NUM_CH, 12, number of monitored channels; matches the `axis_block_sigs` width.
- CNT_W, 16, stall counter width; must satisfy 2^CNT_W > STALL_THRESH.
- STALL_THRESH, 1024, consecutive stall cycles before a channel is flagged; must be >= 1, and 0 is an elaboration error.
- DIR_MASK, {NUM_CH{1'b0}}, per-channel direction:
  - bit=0: producer side; stall = valid & !ready.
  - bit=1: consumer side; stall = ready & !valid.

Ports:
- clock  in  1  design clock
- reset  in  1  synchronous, active-high reset
- ch_valid  in  NUM_CH  per-channel TVALID / FIFO not-empty
- ch_ready  in  NUM_CH  per-channel TREADY / FIFO not-full
- ch_active  in  NUM_CH  channel owner running (not idle); 0 forces the channel out of the block state
- clear  in  1  clears the first-block capture
- axis_block_sigs  out  NUM_CH  registered per-channel block flags
- first_block_vld  out  1  a channel has blocked since reset/clear
- first_block_idx  out  $clog2(NUM_CH)  lowest-index channel blocked when the capture occurred

Behaviour:
- Reset (reset=1 at a rising edge):
  - All counters 0, all channel FSMs in IDLE.
  - axis_block_sigs=0, first_block_vld=0, first_block_idx=0.
  - Reset mid-stall discards all progress.
- Per-channel stall condition s[i] = ch_active[i] & (DIR_MASK[i] ? (ch_ready[i] & ~ch_valid[i]) : (ch_valid[i] & ~ch_ready[i])).
- Per-channel FSM, evaluated every edge:
  - IDLE: if s[i], go to COUNT with cnt=1; if STALL_THRESH==1, go directly to BLOCKED. Otherwise cnt=0.
  - COUNT: if !s[i], go to IDLE with cnt=0. Else cnt++; when the incremented value equals STALL_THRESH, go to BLOCKED.
  - BLOCKED: hold cnt=STALL_THRESH while s[i]; if !s[i], go to IDLE with cnt=0.
- Counter never exceeds STALL_THRESH and never wraps.
- Handshake (valid&ready) or ch_active=0 always makes s[i]=0, which gives an immediate return to IDLE.
- axis_block_sigs[i] = (state==BLOCKED), registered.
  - With s[i] true at edges 1..T (T=STALL_THRESH), the bit is 1 after edge T.
  - The bit drops to 0 after the first edge with s[i]=0.
- First-block capture:
  - At an edge with first_block_vld=0, clear=0 and axis_block_sigs!=0 (registered value): set first_block_vld=1 and first_block_idx = lowest set index.
  - Both values then hold until clear or reset, even after the channel unblocks.
  - clear=1 at an edge: first_block_vld=0, first_block_idx=0; capture is suppressed that edge.
  - A channel still blocked is recaptured on the following edge.
  - Priority: reset > clear > capture.
- Channels are fully independent. Simultaneous entries to BLOCKED are allowed; the lowest index wins the capture.
- No combinational path from any input to any output.

Optional Feature:
- Macro AXIS_BLOCK_STATS_EN.
- When defined:
  - Adds output `block_event_cnt` [31:0].
  - Increments each edge by the number of channels transitioning into BLOCKED that edge (popcount), saturating at 32'hFFFF_FFFF.
  - Cleared by reset and by clear.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then ch_valid[3]=1, ch_ready[3]=0, ch_active=all-1, STALL_THRESH=4, DIR_MASK=0 -> axis_block_sigs=12'h008 after the 4th stalled edge (not before). One edge later first_block_vld=1, first_block_idx=3.
- Same stall on ch3, but ch_ready[3] pulses to 1 at stall edge 3 -> counter restarts; the bit asserts only after 4 further consecutive stall edges.
- ch5 (DIR_MASK[5]=1) with ready=1, valid=0 and ch9 (DIR_MASK=0) with valid=1, ready=0, both starting the same edge -> both bits set on the same edge (12'h220); first_block_idx=5.
- Ch3 blocked, then ch_active[3]=0 -> bit clears next edge while first_block_vld/idx stay 1/3. Assert clear -> vld=0 next edge; with no channel blocked, vld stays 0.
- Ch2 blocked, assert reset for 1 cycle while still stalled -> all outputs 0 after the reset edge; bit re-asserts exactly STALL_THRESH edges after reset deasserts.
- AXIS_BLOCK_STATS_EN defined: ch0 and ch1 block on the same edge, then ch0 unblocks and reblocks once -> block_event_cnt=3; clear -> 0.

Source files
------------

// File: rtl/axis_block_sig_gen.sv
// Per-channel stall filter feeding the deadlock monitors: flags a channel once it has stalled
// STALL_THRESH consecutive cycles and latches the first blocked channel. Optional AXIS_BLOCK_STATS_EN adds block_event_cnt.
module axis_block_sig_gen #(
  parameter int                NUM_CH       = 12,
  parameter int                CNT_W        = 16,
  parameter int                STALL_THRESH = 1024,
  parameter logic [NUM_CH-1:0] DIR_MASK     = {NUM_CH{1'b0}},
  localparam int               IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_active,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              first_block_vld,
`ifdef AXIS_BLOCK_STATS_EN
  output logic [31:0]       block_event_cnt,
`endif
  output logic [IDX_W-1:0]  first_block_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_BLOCKED} ch_state_e;

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  if (STALL_THRESH < 1) begin : g_bad_thresh
    $error("axis_block_sig_gen: STALL_THRESH must be >= 1");
  end

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] entering;
  logic [NUM_CH-1:0] block_sigs_q, block_sigs_d;
  logic              first_vld_q, first_vld_d;
  logic [IDX_W-1:0]  first_idx_q, first_idx_d;
  logic [IDX_W-1:0]  lowest_idx;

  // Direction selects which half of a missing handshake counts as a stall.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stall[i] = ch_active[i] & (DIR_MASK[i] ? (ch_ready[i] & ~ch_valid[i])
                                             : (ch_valid[i] & ~ch_ready[i]));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (stall[i]) begin
            cnt_d[i]   = ONE_C;
            state_d[i] = (THRESH_C == ONE_C) ? ST_BLOCKED : ST_COUNT;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_COUNT: begin
          if (!stall[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + ONE_C;
            if (cnt_q[i] + ONE_C == THRESH_C) state_d[i] = ST_BLOCKED;
          end
        end
        ST_BLOCKED: begin
          if (!stall[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = THRESH_C;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Flags are precomputed from the next state so the outputs come straight from flops.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      block_sigs_d[i] = (state_d[i] == ST_BLOCKED);
      entering[i]     = (state_d[i] == ST_BLOCKED) && (state_q[i] != ST_BLOCKED);
    end
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (block_sigs_q[i]) lowest_idx = IDX_W'(i);
    end
  end

  always_comb begin
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;
    if (clear) begin
      first_vld_d = 1'b0;
      first_idx_d = '0;
    end else if (!first_vld_q && (|block_sigs_q)) begin
      first_vld_d = 1'b1;
      first_idx_d = lowest_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      block_sigs_q <= '0;
      first_vld_q  <= 1'b0;
      first_idx_q  <= '0;
    end else begin
      block_sigs_q <= block_sigs_d;
      first_vld_q  <= first_vld_d;
      first_idx_q  <= first_idx_d;
    end
  end

  assign axis_block_sigs = block_sigs_q;
  assign first_block_vld = first_vld_q;
  assign first_block_idx = first_idx_q;

`ifdef AXIS_BLOCK_STATS_EN
  localparam int NE_W = $clog2(NUM_CH + 1);

  logic [31:0]     evt_cnt_q, evt_cnt_d;
  logic [NE_W-1:0] n_enter;
  logic [32:0]     evt_sum;

  // Saturating count of entries into BLOCKED across all channels.
  always_comb begin
    n_enter = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_enter = n_enter + NE_W'(entering[i]);
    end
    evt_sum = {1'b0, evt_cnt_q} + 33'(n_enter);
    if (clear)           evt_cnt_d = '0;
    else if (evt_sum[32]) evt_cnt_d = 32'hFFFF_FFFF;
    else                 evt_cnt_d = evt_sum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) evt_cnt_q <= '0;
    else       evt_cnt_q <= evt_cnt_d;
  end

  assign block_event_cnt = evt_cnt_q;
`else
  logic unused_entering;
  assign unused_entering = ^entering;
`endif

endmodule
